arbitro_memoria: RTL and testbench

Two-port arbiter sharing the single-port data memory between the CPU datapath and an external requester (program loader / debug port). It has round-robin fairness, a bounded external burst lock, and a CPU stall output.

- Placement: sits between the CPU's data-memory signals (write enable, address from register b, write data from register a) and `memoria_dados`.
- Memory interface: the memory keeps its synchronous write and combinational read.
- CPU stall: `stall` gates the program counter while the CPU waits for the memory.

---
 rtl/arbitro_memoria.sv | 154 +++++++++++++++
 tb/tb_arbitro_memoria.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/arbitro_memoria.sv
// arbitro_memoria: round-robin arbiter sharing the single-port data memory between the CPU and an
// external requester, with bounded external lock bursts. Define ARB_PARK_CPU_EN to park ownership on the CPU when idle.
module arbitro_memoria #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic              ext_lock,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned      CNT_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } owner_t;

    typedef enum logic {
        LAST_CPU = 1'b0,
        LAST_EXT = 1'b1
    } last_t;

`ifdef ARB_PARK_CPU_EN
    localparam owner_t IDLE_OWNER = OWN_CPU;
`else
    localparam owner_t IDLE_OWNER = OWN_NONE;
`endif

    owner_t           r_owner;
    last_t            r_last;
    logic [CNT_W-1:0] r_burst_cnt;

    owner_t           w_owner_nxt;
    last_t            w_last_nxt;
    logic [CNT_W-1:0] w_burst_nxt;
    logic             w_cpu_acc;
    logic             w_ext_acc;
    logic             w_limit;

    // State register; reset parks ownership and lets the CPU win the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner     <= IDLE_OWNER;
            r_last      <= LAST_EXT;
            r_burst_cnt <= '0;
        end else begin
            r_owner     <= w_owner_nxt;
            r_last      <= w_last_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    // Next owner, round-robin history and burst counter
    always_comb begin
        w_owner_nxt = IDLE_OWNER;
        w_last_nxt  = r_last;
        w_burst_nxt = '0;
        w_cpu_acc   = (r_owner == OWN_CPU) && cpu_req;
        w_ext_acc   = (r_owner == OWN_EXT) && ext_req;
        w_limit     = (r_burst_cnt >= CNT_MAX);

        if (w_cpu_acc) begin
            w_last_nxt = LAST_CPU;
        end else if (w_ext_acc) begin
            w_last_nxt = LAST_EXT;
        end

        case (r_owner)
            OWN_NONE: begin
                if (cpu_req && ext_req) begin
                    w_owner_nxt = (r_last == LAST_EXT) ? OWN_CPU : OWN_EXT;
                end else if (cpu_req) begin
                    w_owner_nxt = OWN_CPU;
                end else if (ext_req) begin
                    w_owner_nxt = OWN_EXT;
                end
            end
            OWN_CPU: begin
                if (ext_req) begin
                    w_owner_nxt = OWN_EXT;
                end else if (cpu_req) begin
                    w_owner_nxt = OWN_CPU;
                end
            end
            OWN_EXT: begin
                if (ext_req && ext_lock && !w_limit) begin
                    w_owner_nxt = OWN_EXT;
                end else if (ext_req) begin
                    w_owner_nxt = cpu_req ? OWN_CPU : OWN_EXT;
                end else if (cpu_req) begin
                    w_owner_nxt = OWN_CPU;
                end
            end
            default: w_owner_nxt = IDLE_OWNER;
        endcase

        // Counts only while EXT keeps ownership; any hand-over restarts it
        if ((r_owner == OWN_EXT) && (w_owner_nxt == OWN_EXT)) begin
            w_burst_nxt = w_limit ? r_burst_cnt : r_burst_cnt + CNT_W'(1);
        end
    end

    // Memory datapath follows the current owner
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_owner)
            OWN_CPU: begin
                mem_we    = cpu_we && cpu_req;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            OWN_EXT: begin
                mem_we    = ext_we && ext_req;
                mem_addr  = ext_addr;
                mem_wdata = ext_wdata;
            end
            default: begin
                mem_we    = 1'b0;
                mem_addr  = '0;
                mem_wdata = '0;
            end
        endcase
    end

    assign cpu_gnt   = (r_owner == OWN_CPU);
    assign ext_gnt   = (r_owner == OWN_EXT);
    assign stall     = cpu_req && !cpu_gnt;
    assign cpu_rdata = mem_rdata;
    assign ext_rdata = mem_rdata;

endmodule

// File: tb/tb_arbitro_memoria.sv
// tb_arbitro_memoria: directed scoreboard bench for arbitro_memoria in its default build (idle owner NONE),
// with a behavioural single-port memory (sync write, combinational read) on the memory side.
`timescale 1ns/1ps
module tb_arbitro_memoria;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0] cpu_addr = '0, cpu_wdata = '0;
    logic       cpu_gnt, stall;
    logic [7:0] cpu_rdata;
    logic       ext_req = 1'b0, ext_we = 1'b0, ext_lock = 1'b0;
    logic [7:0] ext_addr = '0, ext_wdata = '0;
    logic       ext_gnt;
    logic [7:0] ext_rdata;
    logic       mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;
    int row    = 0;

    typedef struct packed {
        logic       cpu_gnt;
        logic       ext_gnt;
        logic       stall;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       chk_rd;
        logic [7:0] rdata;
    } exp_t;

    exp_t q[$];

    arbitro_memoria #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .stall(stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rdata(ext_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL row %0d %s: got %h, expected %h", row, name, act, exp);
        end
    endtask

    // Monitor: one expected record per driven cycle, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("cpu_gnt",   8'(cpu_gnt), 8'(e.cpu_gnt));
            chk("ext_gnt",   8'(ext_gnt), 8'(e.ext_gnt));
            chk("stall",     8'(stall),   8'(e.stall));
            chk("mem_we",    8'(mem_we),  8'(e.we));
            chk("mem_addr",  mem_addr,    e.addr);
            chk("mem_wdata", mem_wdata,   e.wdata);
            if (e.chk_rd) begin
                chk("cpu_rdata", cpu_rdata, e.rdata);
                chk("ext_rdata", ext_rdata, e.rdata);
            end
            row++;
        end
    end

    // One cycle of stimulus; flags = {cpu_gnt, ext_gnt, stall, mem_we}
    task automatic cyc(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                       input logic er, input logic ew, input logic el,
                       input logic [7:0] ea, input logic [7:0] ed,
                       input logic [3:0] flags, input logic [7:0] ma, input logic [7:0] md,
                       input logic chk_rd, input logic [7:0] rd,
                       input logic rst_v, input logic mid_rst);
        exp_t e;
        @(posedge clk);
        #1;
        rst = rst_v;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        ext_req = er; ext_we = ew; ext_lock = el; ext_addr = ea; ext_wdata = ed;
        e.cpu_gnt = flags[3];
        e.ext_gnt = flags[2];
        e.stall   = flags[1];
        e.we      = flags[0];
        e.addr    = ma;
        e.wdata   = md;
        e.chk_rd  = chk_rd;
        e.rdata   = rd;
        q.push_back(e);
        if (mid_rst) begin
            #2;
            rst = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset held: no grants, stall follows cpu_req
        cyc(1,1,8'h10,8'hA5, 0,0,0,8'h00,8'h00, 4'b0010, 8'h00,8'h00, 0,8'h00, 1,0);
        // Lone CPU write after reset: one stall cycle, then the write
        cyc(1,1,8'h10,8'hA5, 0,0,0,8'h00,8'h00, 4'b0010, 8'h00,8'h00, 0,8'h00, 0,0);
        cyc(1,1,8'h10,8'hA5, 0,0,0,8'h00,8'h00, 4'b1001, 8'h10,8'hA5, 0,8'h00, 0,0);
        cyc(1,0,8'h10,8'h00, 0,0,0,8'h00,8'h00, 4'b1000, 8'h10,8'h00, 1,8'hA5, 0,0);
        cyc(0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 4'b1000, 8'h00,8'h00, 0,8'h00, 0,0);
        cyc(0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 4'b0000, 8'h00,8'h00, 0,8'h00, 0,0);
        // Tie from idle with last=CPU: EXT first, then alternation
        cyc(1,1,8'h30,8'h11, 1,1,0,8'h31,8'h22, 4'b0010, 8'h00,8'h00, 0,8'h00, 0,0);
        cyc(1,1,8'h30,8'h11, 1,1,0,8'h31,8'h22, 4'b0111, 8'h31,8'h22, 0,8'h00, 0,0);
        cyc(1,1,8'h30,8'h11, 1,1,0,8'h31,8'h22, 4'b1001, 8'h30,8'h11, 0,8'h00, 0,0);
        cyc(1,1,8'h30,8'h11, 1,1,0,8'h31,8'h22, 4'b0111, 8'h31,8'h22, 0,8'h00, 0,0);
        // Locked EXT burst against a waiting CPU: exactly 4 stall cycles
        cyc(1,0,8'h31,8'h00, 1,1,1,8'h40,8'h33, 4'b1000, 8'h31,8'h00, 1,8'h22, 0,0);
        for (int i = 0; i < 4; i++)
            cyc(1,0,8'h31,8'h00, 1,1,1,8'h40,8'h33, 4'b0111, 8'h40,8'h33, 0,8'h00, 0,0);
        cyc(1,0,8'h31,8'h00, 0,0,0,8'h00,8'h00, 4'b1000, 8'h31,8'h00, 1,8'h22, 0,0);
        // Lock without contention: EXT keeps memory, counter must saturate
        cyc(0,0,8'h00,8'h00, 1,0,1,8'h40,8'h00, 4'b1000, 8'h00,8'h00, 0,8'h00, 0,0);
        for (int i = 0; i < 10; i++)
            cyc(0,0,8'h00,8'h00, 1,0,1,8'h40,8'h00, 4'b0100, 8'h40,8'h00, 1,8'h33, 0,0);
        cyc(1,1,8'h50,8'h44, 1,0,1,8'h40,8'h00, 4'b0110, 8'h40,8'h00, 1,8'h33, 0,0);
        cyc(1,1,8'h50,8'h44, 1,0,1,8'h40,8'h00, 4'b1001, 8'h50,8'h44, 0,8'h00, 0,0);
        // EXT granted without request: no write, address still from EXT
        cyc(1,0,8'h50,8'h00, 0,1,0,8'h40,8'h55, 4'b0110, 8'h40,8'h55, 0,8'h00, 0,0);
        cyc(1,0,8'h50,8'h00, 0,0,0,8'h00,8'h00, 4'b1000, 8'h50,8'h00, 1,8'h44, 0,0);
        cyc(0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 4'b1000, 8'h00,8'h00, 0,8'h00, 0,0);
        // Async reset during an EXT write to 8'h20
        cyc(0,0,8'h00,8'h00, 1,1,1,8'h20,8'h66, 4'b0000, 8'h00,8'h00, 0,8'h00, 0,0);
        cyc(0,0,8'h00,8'h00, 1,1,1,8'h20,8'h66, 4'b0000, 8'h00,8'h00, 0,8'h00, 0,1);
        // After reset: CPU wins the tie, grants alternate, 8'h20 untouched
        cyc(1,0,8'h20,8'h00, 1,0,0,8'h31,8'h00, 4'b0010, 8'h00,8'h00, 0,8'h00, 0,0);
        cyc(1,0,8'h20,8'h00, 1,0,0,8'h31,8'h00, 4'b1000, 8'h20,8'h00, 1,8'h00, 0,0);
        cyc(1,0,8'h20,8'h00, 1,0,0,8'h31,8'h00, 4'b0110, 8'h31,8'h00, 1,8'h22, 0,0);
        cyc(1,0,8'h20,8'h00, 1,0,0,8'h31,8'h00, 4'b1000, 8'h20,8'h00, 1,8'h00, 0,0);
        // EXT drops request with no CPU waiting: ownership returns to idle
        cyc(0,0,8'h00,8'h00, 0,1,0,8'h31,8'h77, 4'b0100, 8'h31,8'h77, 0,8'h00, 0,0);
        cyc(0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 4'b0000, 8'h00,8'h00, 0,8'h00, 0,0);

        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
